// File: rtl/sys_array_tiled_mac_if.sv
// Control/data bundle for the tiled systolic MAC: job request, operand matrices,
// result matrix and status strobes.
interface sys_array_tiled_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int MAX_M      = 8,
  parameter int MAX_K      = 8,
  parameter int MAX_N      = 8
);
  logic                                          start;
  logic [$clog2(MAX_M+1)-1:0]                    dim_m;
  logic [$clog2(MAX_K+1)-1:0]                    dim_k;
  logic [$clog2(MAX_N+1)-1:0]                    dim_n;
  logic                                          acc_mode;
  logic                                          signed_mode;
  logic [MAX_M-1:0][MAX_K-1:0][DATA_WIDTH-1:0]   input_data_a;
  logic [MAX_K-1:0][MAX_N-1:0][DATA_WIDTH-1:0]   weights;
  logic [MAX_M-1:0][MAX_N-1:0][ACC_WIDTH-1:0]    out_data;
  logic                                          busy;
  logic                                          done;
  logic                                          error;

  modport master (
    output start, dim_m, dim_k, dim_n, acc_mode, signed_mode, input_data_a, weights,
    input  out_data, busy, done, error
  );

  modport slave (
    input  start, dim_m, dim_k, dim_n, acc_mode, signed_mode, input_data_a, weights,
    output out_data, busy, done, error
  );
endinterface

// File: rtl/sys_array_tiled_mac.sv
// Output-stationary ARRAY_W x ARRAY_L systolic MAC that walks C = A*B (or C += A*B)
// tile by tile, row-major over output tiles.
module sys_array_tiled_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);
  logic [2*DATA_WIDTH-1:0] prod_s, prod_u;
  logic [ACC_WIDTH-1:0]    prod_ext;

  assign prod_s   = (2*DATA_WIDTH)'($signed(a_in)) * (2*DATA_WIDTH)'($signed(b_in));
  assign prod_u   = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
  assign prod_ext = signed_mode ? ACC_WIDTH'($signed(prod_s)) : ACC_WIDTH'(prod_u);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end
endmodule

module sys_array_tiled_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int MAX_M      = 8,
  parameter int MAX_K      = 8,
  parameter int MAX_N      = 8
) (
  input logic clk,
  input logic reset,
  sys_array_tiled_mac_if.slave bus
);
  localparam int MW  = $clog2(MAX_M+1);
  localparam int KW  = $clog2(MAX_K+1);
  localparam int NW  = $clog2(MAX_N+1);
  localparam int TW  = $clog2(MAX_K+ARRAY_W+ARRAY_L);
  localparam int TRW = $clog2(MAX_M+1);
  localparam int TCW = $clog2(MAX_N+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]     state;
  logic [MW-1:0]  m_r;
  logic [KW-1:0]  k_r;
  logic [NW-1:0]  n_r;
  logic           acc_r, sgn_r;
  logic [TRW-1:0] tile_r;
  logic [TCW-1:0] tile_c;
  logic [TW-1:0]  t;
  logic           bad_dims, last_feed, last_tc, last_tr;

  logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0] a_in, b_in, a_out, b_out;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  pe_acc;
  logic [ARRAY_W-1:0][DATA_WIDTH-1:0]              a_edge;
  logic [ARRAY_L-1:0][DATA_WIDTH-1:0]              b_edge;

  assign bad_dims  = (bus.dim_m == '0) || (int'(bus.dim_m) > MAX_M) ||
                     (bus.dim_k == '0) || (int'(bus.dim_k) > MAX_K) ||
                     (bus.dim_n == '0) || (int'(bus.dim_n) > MAX_N);
  // Last operand k=K-1 reaches the far corner PE at t = K+W+L-3.
  assign last_feed = int'(t) == int'(k_r) + ARRAY_W + ARRAY_L - 3;
  assign last_tc   = (int'(tile_c) + 1) * ARRAY_L >= int'(n_r);
  assign last_tr   = (int'(tile_r) + 1) * ARRAY_W >= int'(m_r);

  assign bus.busy  = (state == S_LOAD) || (state == S_CLEAR) ||
                     (state == S_FEED) || (state == S_WRITE);
  assign bus.done  = (state == S_DONE);
  assign bus.error = (state == S_ERR);

  // Skewed edge feed: row r sees A[i][t-r], column c sees B[t-c][j]; anything
  // outside the job's M/K/N bounds stays zero.
  always_comb begin
    a_edge = '0;
    for (int r = 0; r < ARRAY_W; r++)
      for (int i = r; i < MAX_M; i += ARRAY_W)
        if (int'(tile_r) == i / ARRAY_W && i < int'(m_r))
          for (int k = 0; k < MAX_K; k++)
            if (k < int'(k_r) && int'(t) == k + r)
              a_edge[r] = bus.input_data_a[i][k];
  end

  always_comb begin
    b_edge = '0;
    for (int c = 0; c < ARRAY_L; c++)
      for (int j = c; j < MAX_N; j += ARRAY_L)
        if (int'(tile_c) == j / ARRAY_L && j < int'(n_r))
          for (int k = 0; k < MAX_K; k++)
            if (k < int'(k_r) && int'(t) == k + c)
              b_edge[c] = bus.weights[k][j];
  end

  for (genvar r = 0; r < ARRAY_W; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_L; c++) begin : g_col
      if (c == 0) begin : g_aedge
        assign a_in[r][c] = a_edge[r];
      end else begin : g_ain
        assign a_in[r][c] = a_out[r][c-1];
      end
      if (r == 0) begin : g_bedge
        assign b_in[r][c] = b_edge[c];
      end else begin : g_bin
        assign b_in[r][c] = b_out[r-1][c];
      end

      sys_array_tiled_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk         (clk),
        .reset       (reset),
        .clr         (state == S_CLEAR),
        .en          (state == S_FEED),
        .signed_mode (sgn_r),
        .a_in        (a_in[r][c]),
        .b_in        (b_in[r][c]),
        .a_out       (a_out[r][c]),
        .b_out       (b_out[r][c]),
        .acc         (pe_acc[r][c])
      );
    end
  end

  // Job parameters are captured on the accepting start edge so LOAD already
  // acts on the job's own acc_mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      m_r    <= '0;
      k_r    <= '0;
      n_r    <= '0;
      acc_r  <= 1'b0;
      sgn_r  <= 1'b0;
      tile_r <= '0;
      tile_c <= '0;
      t      <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          if (bad_dims) state <= S_ERR;
          else begin
            state <= S_LOAD;
            m_r   <= bus.dim_m;
            k_r   <= bus.dim_k;
            n_r   <= bus.dim_n;
            acc_r <= bus.acc_mode;
            sgn_r <= bus.signed_mode;
          end
        end
        S_LOAD: begin
          tile_r <= '0;
          tile_c <= '0;
          state  <= S_CLEAR;
        end
        S_CLEAR: begin
          t     <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          t <= t + TW'(1);
          if (last_feed) state <= S_WRITE;
        end
        S_WRITE: begin
          if (last_tc) begin
            tile_c <= '0;
            if (last_tr) state <= S_DONE;
            else begin
              tile_r <= tile_r + TRW'(1);
              state  <= S_CLEAR;
            end
          end else begin
            tile_c <= tile_c + TCW'(1);
            state  <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.out_data <= '0;
    else if (state == S_LOAD && !acc_r) bus.out_data <= '0;
    else if (state == S_WRITE) begin
      for (int i = 0; i < MAX_M; i++)
        for (int j = 0; j < MAX_N; j++)
          if (i < int'(m_r) && j < int'(n_r) &&
              int'(tile_r) == i / ARRAY_W && int'(tile_c) == j / ARRAY_L)
            bus.out_data[i][j] <= bus.out_data[i][j] + pe_acc[i % ARRAY_W][j % ARRAY_L];
    end
  end
endmodule
